// File: rtl/reg_file_bank.sv
// ---------------------------------------------------------------------------
// reg_file_bank
//   Register file with two registered read ports, one write port and a
//   hardware clear sweep. Register 0 is hard-wired to zero. A clear request
//   (or reset) zeroes registers 1..NUM_REG-1, one per cycle. During the sweep
//   busy is high, writes and further clear requests are ignored, and both
//   read ports return zero.
//
//   Optional feature: define REGFILE_BYPASS_EN to forward write data to a
//   read port that addresses the register being written in the same cycle.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; NUM_REG = 2**ADDR_W
//
// Ports
//   clock      single clock, rising-edge active
//   reset      asynchronous active-low reset
//   rs1, rs2   read addresses, ports 1 and 2
//   rd         write address
//   writedata  write data
//   write      write enable
//   clear      single-cycle request to zero all registers
//   reg1, reg2 registered read data, ports 1 and 2
//   busy       high while the clear sweep runs
// ---------------------------------------------------------------------------
module reg_file_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writedata,
    input  logic              write,
    input  logic              clear,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy
);

    localparam int NUM_REG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(NUM_REG - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clear_ptr;
    logic [ADDR_W-1:0] clear_ptr_nxt;
    logic              wr_en_p0;

    // Storage has no reset: the sweep is the only mechanism that clears it.
    logic [DATA_W-1:0] mem [NUM_REG];

    assign busy     = (state == CLEAR);
    assign wr_en_p0 = write && !busy && (rd != '0);

    // ---- control: sweep FSM state register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            clear_ptr <= PTR_FIRST;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt     = CLEAR;
                    clear_ptr_nxt = PTR_FIRST;
                end
            end
            CLEAR: begin
                // Pointer parks on the last register instead of wrapping.
                if (clear_ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    clear_ptr_nxt = clear_ptr + PTR_FIRST;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- storage: sweep zeroing or normal write ----
    // A write in the same IDLE cycle as a clear request lands first; the
    // sweep that starts next cycle then zeroes it.
    always_ff @(posedge clock) begin
        if (busy) begin
            mem[clear_ptr] <= '0;
        end else if (wr_en_p0) begin
            mem[rd] <= writedata;
        end
    end

    // ---- read ports: one-cycle registered output ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg1 <= '0;
        end else if (busy) begin
            reg1 <= '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en_p0 && (rs1 == rd)) begin
            reg1 <= writedata;
`endif
        end else if (rs1 == '0) begin
            reg1 <= '0;
        end else begin
            reg1 <= mem[rs1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg2 <= '0;
        end else if (busy) begin
            reg2 <= '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en_p0 && (rs2 == rd)) begin
            reg2 <= writedata;
`endif
        end else if (rs2 == '0) begin
            reg2 <= '0;
        end else begin
            reg2 <= mem[rs2];
        end
    end

endmodule
